// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake carrying instruction + PC+4.
// Define IFID_SKID_BUF_EN for a two-entry skid buffer with registered in_ready; otherwise single entry.
module ifid_skid_stage #(
    parameter int INST_W         = 32,
    parameter int PC_W           = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);
    // State encoding equals the number of held entries, so occupancy is the state itself.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_FULL  = 2'd1;
`ifdef IFID_SKID_BUF_EN
    localparam logic [1:0] S_SKID  = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [INST_W-1:0] r_main_inst;
    logic [PC_W-1:0]   r_main_pc;
    logic              w_in_fire;
    logic              w_out_fire;

    assign out_valid = (r_state != S_EMPTY);
    assign occupancy = r_state;
    assign out_inst  = r_main_inst;
    assign out_pc    = r_main_pc;
`ifdef IFID_SKID_BUF_EN
    assign in_ready  = (r_state != S_SKID);
`else
    assign in_ready  = !out_valid || out_ready;
`endif
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

`ifdef IFID_SKID_BUF_EN
    logic [INST_W-1:0] r_skid_inst;
    logic [PC_W-1:0]   r_skid_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                r_skid_inst <= '0;
                r_skid_pc   <= '0;
            end
        end else if (r_state == S_FULL && w_in_fire && !w_out_fire) begin
            r_skid_inst <= in_inst;
            r_skid_pc   <= in_pc;
        end
    end
`endif

    // NOTE: payload registers are reset too, so out_inst/out_pc read 0 while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main_inst <= '0;
            r_main_pc   <= '0;
        end else if (flush) begin
            // Flush wins over any transfer; the input offered this cycle is dropped.
            r_state <= S_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                r_main_inst <= '0;
                r_main_pc   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees pre-edge state.
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_inst <= in_inst;
                        r_main_pc   <= in_pc;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_inst <= in_inst;
                        r_main_pc   <= in_pc;
                    end else if (w_out_fire) begin
                        r_state <= S_EMPTY;
                        if (CLEAR_ON_FLUSH) begin
                            r_main_inst <= '0;
                            r_main_pc   <= '0;
                        end
                    end
`ifdef IFID_SKID_BUF_EN
                    else if (w_in_fire) begin
                        r_state <= S_SKID;
                    end
`endif
                end
`ifdef IFID_SKID_BUF_EN
                S_SKID: begin
                    if (w_out_fire) begin
                        r_main_inst <= r_skid_inst;
                        r_main_pc   <= r_skid_pc;
                        r_state     <= S_FULL;
                    end
                end
`endif
                default: r_state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: directed scenarios plus a FIFO scoreboard on the output handshake.
// Covers both builds; scenario shapes follow whether IFID_SKID_BUF_EN is defined.
`timescale 1ns/1ps
module tb_ifid_skid_stage;
    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } xfer_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [INST_W-1:0] in_inst = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic [1:0]        occupancy;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_pop = 0;
    xfer_t sb_q[$];
    xfer_t sb_exp;

    always #5 clk = ~clk;

    ifid_skid_stage #(.INST_W(INST_W), .PC_W(PC_W), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .occupancy(occupancy)
    );

    // Scoreboard: sampled on the falling edge, midway between active edges.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: got inst=%h pc=%h, nothing expected", out_inst, out_pc);
                end else begin
                    sb_exp = sb_q.pop_front();
                    if (out_inst !== sb_exp.inst || out_pc !== sb_exp.pc) begin
                        n_bad++;
                        $display("FAIL sb_payload: got inst=%h pc=%h, want inst=%h pc=%h",
                                 out_inst, out_pc, sb_exp.inst, sb_exp.pc);
                    end
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_inst, in_pc});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [INST_W-1:0] inst, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic expect_empty(input string tag);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_out_valid: got %0b want 0", tag, out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL %s_occupancy: got %0d want 0", tag, occupancy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %0b want 1", tag, in_ready); end
        n_cmp++; if (out_inst !== '0) begin n_bad++; $display("FAIL %s_out_inst: got %h want 0", tag, out_inst); end
        n_cmp++; if (out_pc !== '0) begin n_bad++; $display("FAIL %s_out_pc: got %h want 0", tag, out_pc); end
    endtask

    task automatic test_reset();
        offer(32'hBAD0_0013, 64'hFFF0);
        cyc();
        cyc();
        expect_empty("rst_held");
        in_valid = 1'b0;
        reset    = 1'b1;
        cyc();
        expect_empty("rst_release");
    endtask

    task automatic test_stream();
        int p0;
        p0 = n_pop;
        out_ready = 1'b1;
        offer(32'h0050_0093, 64'h4);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_rdy0: got %0b want 1", in_ready); end
        cyc();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_latency: got %0b want 1", out_valid); end
        n_cmp++; if (out_inst !== 32'h0050_0093) begin n_bad++; $display("FAIL stream_inst0: got %h want 00500093", out_inst); end
        offer(32'h00A0_0113, 64'h8);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_rdy1: got %0b want 1", in_ready); end
        cyc();
        n_cmp++; if (out_inst !== 32'h00A0_0113 || out_pc !== 64'h8) begin
            n_bad++; $display("FAIL stream_inst1: got %h/%h want 00a00113/8", out_inst, out_pc); end
        for (int i = 0; i < 8; i++) begin
            offer(32'h1000_0013 + INST_W'(i << 7), 64'hC + PC_W'(4 * i));
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL burst_rdy%0d: got %0b want 1", i, in_ready); end
            cyc();
            n_cmp++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
                n_bad++; $display("FAIL burst_occ%0d: got v=%0b occ=%0d want v=1 occ=1", i, out_valid, occupancy); end
        end
        in_valid = 1'b0;
        cyc();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_bad++; $display("FAIL stream_drain: got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
        n_cmp++; if (n_pop - p0 !== 10) begin n_bad++; $display("FAIL stream_count: got %0d want 10", n_pop - p0); end
    endtask

    task automatic test_backpressure();
        int  p0;
        p0 = n_pop;
        out_ready = 1'b0;
`ifdef IFID_SKID_BUF_EN
        begin
            logic acc;
            acc = 1'b0;
            offer(32'hA000_0013, 64'h100);
            cyc();
            n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                n_bad++; $display("FAIL bp_a: got occ=%0d rdy=%0b want 1/1", occupancy, in_ready); end
            offer(32'hB000_0013, 64'h104);
            cyc();
            n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_b: got occ=%0d rdy=%0b want 2/0", occupancy, in_ready); end
            offer(32'hC000_0013, 64'h108);
            cyc();
            n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_inst !== 32'hA000_0013) begin
                n_bad++; $display("FAIL bp_c_held: got occ=%0d rdy=%0b inst=%h want 2/0/a0000013", occupancy, in_ready, out_inst); end
            out_ready = 1'b1;
            for (int i = 0; i < 6 && !acc; i++) begin
                @(negedge clk);
                acc = in_ready;
                cyc();
            end
            n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL bp_c_accept: got %0b want 1", acc); end
            in_valid = 1'b0;
            for (int i = 0; i < 6 && out_valid; i++) cyc();
            n_cmp++; if (n_pop - p0 !== 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", n_pop - p0); end
        end
`else
        offer(32'hA000_0013, 64'h100);
        cyc();
        n_cmp++; if (out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_full: got v=%0b occ=%0d rdy=%0b want 1/1/0", out_valid, occupancy, in_ready); end
        offer(32'hB000_0013, 64'h104);
        cyc();
        n_cmp++; if (out_inst !== 32'hA000_0013 || occupancy !== 2'd1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold: got inst=%h occ=%0d rdy=%0b want a0000013/1/0", out_inst, occupancy, in_ready); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_comb_rdy: got %0b want 1", in_ready); end
        cyc();
        n_cmp++; if (out_inst !== 32'hB000_0013) begin n_bad++; $display("FAIL bp_b_out: got %h want b0000013", out_inst); end
        in_valid = 1'b0;
        cyc();
        n_cmp++; if (n_pop - p0 !== 2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", n_pop - p0); end
`endif
    endtask

    task automatic test_flush_hold();
        out_ready = 1'b0;
        offer(32'hA100_0013, 64'h200);
        cyc();
`ifdef IFID_SKID_BUF_EN
        offer(32'hB100_0013, 64'h204);
        cyc();
        n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL fl_fill: got %0d want 2", occupancy); end
`endif
        offer(32'hDEAD_0013, 64'h208);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_empty("fl_hold");
        out_ready = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_no_d: got %0b want 0", out_valid); end
        offer(32'hE000_0013, 64'h20C);
        cyc();
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'hE000_0013) begin
            n_bad++; $display("FAIL fl_after: got v=%0b inst=%h want 1/e0000013", out_valid, out_inst); end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_flush_outfire();
        int p0;
        out_ready = 1'b1;
        offer(32'hA200_0013, 64'h300);
        cyc();
        p0 = n_pop;
        offer(32'hF000_0013, 64'h304);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_empty("flo");
        cyc();
        cyc();
        n_cmp++; if (n_pop - p0 !== 1) begin n_bad++; $display("FAIL flo_count: got %0d want 1", n_pop - p0); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        offer(32'hA300_0013, 64'h400);
        cyc();
`ifdef IFID_SKID_BUF_EN
        offer(32'hB300_0013, 64'h404);
        cyc();
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL ar_fill: got occ=%0d rdy=%0b want 2/0", occupancy, in_ready); end
`else
        n_cmp++; if (occupancy !== 2'd1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL ar_fill: got occ=%0d rdy=%0b want 1/0", occupancy, in_ready); end
`endif
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        expect_empty("ar_async");
        @(posedge clk);
        #3;
        reset = 1'b1;
        cyc();
        expect_empty("ar_release");
        out_ready = 1'b1;
        offer(32'h0630_0193, 64'h408);
        cyc();
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'h0630_0193) begin
            n_bad++; $display("FAIL ar_restart: got v=%0b inst=%h want 1/06300193", out_valid, out_inst); end
        in_valid = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_hold();
        test_flush_outfire();
        test_async_reset();
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL final_drain: got %0d pending want 0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
